// File: rtl/wb_host_pkg.sv
// wb_host_pkg: shared state encoding and default timeout for wb_host_master.
package wb_host_pkg;
   typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;
   localparam int DEF_TIMEOUT_CYCLES = 255;
endpackage

// File: rtl/wb_host_master.sv
// wb_host_master: single-outstanding command to Wishbone classic master with wait-state timeout.
module wb_host_master
   import wb_host_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
   parameter int ADR_W          = 32
) (
   input  logic             wb_clk_i,
   input  logic             wb_rst_i,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic             cmd_we,
   input  logic [3:0]       cmd_sel,
   input  logic [ADR_W-1:0] cmd_adr,
   input  logic [31:0]      cmd_dat,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [31:0]      rsp_dat,
   output logic             rsp_err,
   output logic             wbm_cyc_o,
   output logic             wbm_stb_o,
   output logic             wbm_we_o,
   output logic [3:0]       wbm_sel_o,
   output logic [ADR_W-1:0] wbm_adr_o,
   output logic [31:0]      wbm_dat_o,
   input  logic [31:0]      wbm_dat_i,
   input  logic             wbm_ack_i,
   output logic             busy
);
   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES - 1);
   state_t state, state_n;
   logic [CW-1:0] cnt;
   logic accept, timeout;
   assign cmd_ready = (state == IDLE) && !wb_rst_i;
   assign accept    = cmd_valid && cmd_ready;
   assign timeout   = (cnt == LIMIT) && !wbm_ack_i;
   assign wbm_cyc_o = (state == BUS);
   assign wbm_stb_o = (state == BUS);
   assign rsp_valid = (state == RESP);
   assign busy      = (state != IDLE);
   always_comb begin
      state_n = state;
      case (state)
         IDLE:    state_n = accept ? BUS : IDLE;
         BUS:     state_n = (wbm_ack_i || timeout) ? RESP : BUS;
         RESP:    state_n = rsp_ready ? IDLE : RESP;
         default: state_n = IDLE;
      endcase
   end
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) state <= IDLE;
      else          state <= state_n;
   end
   // ack outside BUS is deliberately never looked at, so stray acks cannot disturb state
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         wbm_we_o  <= 1'b0;
         wbm_sel_o <= '0;
         wbm_adr_o <= '0;
         wbm_dat_o <= '0;
         rsp_dat   <= '0;
         rsp_err   <= 1'b0;
         cnt       <= '0;
      end else if (accept) begin
         wbm_we_o  <= cmd_we;
         wbm_sel_o <= cmd_sel;
         wbm_adr_o <= cmd_adr;
         wbm_dat_o <= cmd_dat;
         cnt       <= '0;
      end else if (state == BUS) begin
         if (wbm_ack_i) begin
            rsp_dat <= wbm_we_o ? 32'h0 : wbm_dat_i;
            rsp_err <= 1'b0;
         end else if (cnt == LIMIT) begin
            rsp_dat <= 32'h0;
            rsp_err <= 1'b1;
         end else if (cnt != {CW{1'b1}}) begin
            cnt <= cnt + 1'b1;
         end
      end
   end
endmodule
